systolic_feeder: RTL and testbench

//  Operand producer for the array_size x array_size systolic MAC array. Buffers one

---
 rtl/systolic_feeder.sv | 199 +++++++++++++++++++
 tb/tb_systolic_feeder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Operand producer for an array_size x array_size systolic MAC array.
//   The block first buffers one tile from a valid/ready stream. Beat k carries
//   column k of A and row k of B. It then pulses pe_clear for one cycle. Next
//   it streams the tile into the array with diagonal skew and zero padding.
//   After that it idles the buses while the array drains, and finally pulses
//   done.
//
// Ports
//   clk       : single clock, rising edge
//   reset     : synchronous reset, active-low
//   in_valid  : upstream beat valid
//   in_ready  : feeder can accept a beat (IDLE and LOAD only)
//   in_a      : beat k, lane i = A[i][k]
//   in_b      : beat k, lane j = B[k][j]
//   datain    : lane i feeds array row i
//   weightin  : lane j feeds array column j
//   pe_clear  : one-cycle accumulator clear to the array
//   busy      : high whenever the sequencer is not idle
//   done      : one-cycle pulse, array results are final
module systolic_feeder #(
    parameter int array_size = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*array_size-1:0] in_a,
    input  logic [8*array_size-1:0] in_b,
    output logic [8*array_size-1:0] datain,
    output logic [8*array_size-1:0] weightin,
    output logic                    pe_clear,
    output logic                    busy,
    output logic                    done
);

    localparam int N  = array_size;
    localparam int W  = 8 * N;
    localparam int LW = (N > 2) ? $clog2(N) : 1;
    localparam int CW = $clog2(2 * N);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CLEAR = 3'd2,
        FEED  = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   load_cnt_q, load_cnt_d;
    logic [CW-1:0]   feed_cnt_q, feed_cnt_d;
    logic [W-1:0]    buf_a_q [N];
    logic [W-1:0]    buf_a_d [N];
    logic [W-1:0]    buf_b_q [N];
    logic [W-1:0]    buf_b_d [N];
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            pe_clear_q, pe_clear_d;
    logic            done_q, done_d;
    logic [W-1:0]    datain_q, datain_d;
    logic [W-1:0]    weightin_q, weightin_d;
    logic            xfer_s;

    assign xfer_s = in_valid & in_ready_q;

    // Sequencer next state, beat capture and cycle counters
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        feed_cnt_d = feed_cnt_q;
        for (int k = 0; k < N; k++) begin
            buf_a_d[k] = buf_a_q[k];
            buf_b_d[k] = buf_b_q[k];
        end
        case (state_q)
            IDLE: begin
                if (xfer_s) begin
                    buf_a_d[0] = in_a;
                    buf_b_d[0] = in_b;
                    load_cnt_d = LW'(1);
                    state_d    = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (xfer_s) begin
                    buf_a_d[load_cnt_q] = in_a;
                    buf_b_d[load_cnt_q] = in_b;
                    if (load_cnt_q == LW'(N - 1)) begin
                        load_cnt_d = '0;
                        state_d    = CLEAR;
                    end else begin
                        load_cnt_d = load_cnt_q + LW'(1);
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            CLEAR: begin
                feed_cnt_d = '0;
                state_d    = FEED;
            end
            FEED: begin
                // The counter is reused to time the drain in FLUSH.
                if (feed_cnt_q == CW'(2 * N - 2)) begin
                    feed_cnt_d = '0;
                    state_d    = FLUSH;
                end else begin
                    feed_cnt_d = feed_cnt_q + CW'(1);
                end
            end
            FLUSH: begin
                if (feed_cnt_q == CW'(N - 1)) begin
                    feed_cnt_d = '0;
                    state_d    = DONE;
                end else begin
                    feed_cnt_d = feed_cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                load_cnt_d = '0;
                feed_cnt_d = '0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so they can be registered
    always_comb begin
        in_ready_d = (state_d == IDLE) || (state_d == LOAD);
        busy_d     = (state_d != IDLE);
        pe_clear_d = (state_d == CLEAR);
        done_d     = (state_d == DONE);
        datain_d   = '0;
        weightin_d = '0;
        if (state_d == FEED) begin
            // Lane i carries beat k on feed step i+k. This staggers row i and
            // column i by i cycles. Only one k matches per lane, so OR-merge is exact.
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    datain_d[8*i +: 8]   = datain_d[8*i +: 8] |
                        ((int'(feed_cnt_d) == i + k) ? buf_a_d[k][8*i +: 8] : 8'h00);
                    weightin_d[8*i +: 8] = weightin_d[8*i +: 8] |
                        ((int'(feed_cnt_d) == i + k) ? buf_b_d[k][8*i +: 8] : 8'h00);
                end
            end
        end else begin
            datain_d   = '0;
            weightin_d = '0;
        end
    end

    // State, counters, tile buffer and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            feed_cnt_q <= '0;
            for (int k = 0; k < N; k++) begin
                buf_a_q[k] <= '0;
                buf_b_q[k] <= '0;
            end
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            pe_clear_q <= 1'b0;
            done_q     <= 1'b0;
            datain_q   <= '0;
            weightin_q <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            feed_cnt_q <= feed_cnt_d;
            for (int k = 0; k < N; k++) begin
                buf_a_q[k] <= buf_a_d[k];
                buf_b_q[k] <= buf_b_d[k];
            end
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            pe_clear_q <= pe_clear_d;
            done_q     <= done_d;
            datain_q   <= datain_d;
            weightin_q <= weightin_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign pe_clear = pe_clear_q;
    assign done     = done_q;
    assign datain   = datain_q;
    assign weightin = weightin_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder.
// The driver pushes each completed tile into a scoreboard queue. The push
// records the tile's operands and its last-transfer edge. A negedge monitor
// derives the expected outputs for every cycle from the skew rule. A
// behavioural systolic array is driven by the feeder's buses, and its
// accumulators are checked against the plain matrix product at done.
module tb_systolic_feeder;

    localparam int N   = 4;
    localparam int W   = 8 * N;
    localparam int LAT = 3 * N + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ready;
    logic [W-1:0] datain;
    logic [W-1:0] weightin;
    logic         pe_clear;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    systolic_feeder #(.array_size(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .datain   (datain),
        .weightin (weightin),
        .pe_clear (pe_clear),
        .busy     (busy),
        .done     (done)
    );

    // A[r][c] at a[(r*N+c)*8 +: 8], B[r][c] at b[(r*N+c)*8 +: 8]
    typedef struct packed {
        int                 e;
        int                 tag;
        logic [N*N*8-1:0]   a;
        logic [N*N*8-1:0]   b;
    } tile_t;

    tile_t            tq[$];
    int               cyc = 0;
    logic             rst_prev = 1'b0;
    int               beats_loaded = 0;
    logic [N*N*8-1:0] cur_a = '0;
    logic [N*N*8-1:0] cur_b = '0;
    int               cur_tag = 0;
    int               n_cmp = 0;
    int               n_err = 0;
    int               pushed = 0;
    int               aborted = 0;
    int               dones = 0;
    int               acc [N][N];
    int               pa  [N][N];
    int               pw  [N][N];

    function automatic int gm(input logic [N*N*8-1:0] m, input int r, input int c);
        return int'(m[(r*N+c)*8 +: 8]);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Cycle counter, reset sampling and the behavioural MAC array
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= reset;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc[i][j] <= pe_clear ? 0 :
                    acc[i][j] +
                    ((j == 0) ? int'(datain[8*i +: 8]) : pa[i][(j > 0) ? j-1 : 0]) *
                    ((i == 0) ? int'(weightin[8*j +: 8]) : pw[(i > 0) ? i-1 : 0][j]);
                pa[i][j] <= (j == 0) ? int'(datain[8*i +: 8]) : pa[i][(j > 0) ? j-1 : 0];
                pw[i][j] <= (i == 0) ? int'(weightin[8*j +: 8]) : pw[(i > 0) ? i-1 : 0][j];
            end
        end
    end

    task automatic monitor_cycle();
        tile_t        h;
        int           d;
        int           t;
        int           k;
        int           prod;
        logic         act;
        logic [W-1:0] ed;
        logic [W-1:0] ew;
        logic [3:0]   ectl;
        if (!rst_prev) begin
            chk("reset_ctrl", 64'({in_ready, busy, pe_clear, done}), 64'(4'b1000));
            chk("reset_data", {datain, weightin}, 64'd0);
            return;
        end
        act = 1'b0;
        d   = 0;
        h   = '0;
        if (tq.size() > 0) begin
            h   = tq[0];
            d   = cyc - h.e + 1;
            act = (d >= 1) && (d <= LAT);
        end
        ed = '0;
        ew = '0;
        if (act && d >= 2 && d <= 2*N) begin
            t = d - 2;
            for (int i = 0; i < N; i++) begin
                k = t - i;
                if (k >= 0 && k < N) ed[8*i +: 8] = 8'(gm(h.a, i, k));
                if (k >= 0 && k < N) ew[8*i +: 8] = 8'(gm(h.b, k, i));
            end
            if (h.tag == 3 && t == 0) chk("skew_t0", 64'(datain), 64'd0);
            if (h.tag == 3 && t == 3) chk("skew_t3", 64'(datain), 64'h1E150C03);
            if (h.tag == 3 && t == 6) chk("skew_t6", {datain, weightin}, {32'h21000000, 32'h85000000});
        end
        ectl = {!act, act || (beats_loaded > 0), act && (d == 1), act && (d == LAT)};
        chk("ctrl", 64'({in_ready, busy, pe_clear, done}), 64'(ectl));
        chk("datain", 64'(datain), 64'(ed));
        chk("weightin", 64'(weightin), 64'(ew));
        if (act && d == LAT) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    prod = 0;
                    for (int m = 0; m < N; m++) prod += gm(h.a, i, m) * gm(h.b, m, j);
                    chk("macout", 64'(acc[i][j]), 64'(prod));
                    if (h.tag == 2) chk("macout_8", 64'(acc[i][j]), 64'd8);
                end
            end
            dones++;
            void'(tq.pop_front());
        end
    endtask

    // Scoreboard monitor, away from the active edge
    always @(negedge clk) monitor_cycle();

    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic rn);
        tile_t nt;
        @(negedge clk);
        #2;
        reset    = rn;
        in_valid = v;
        in_a     = a;
        in_b     = b;
        if (!rn) begin
            aborted     += tq.size();
            tq.delete();
            beats_loaded = 0;
        end else if (v && in_ready) begin
            for (int l = 0; l < N; l++) begin
                cur_a[(l*N+beats_loaded)*8 +: 8] = a[8*l +: 8];
                cur_b[(beats_loaded*N+l)*8 +: 8] = b[8*l +: 8];
            end
            beats_loaded++;
            if (beats_loaded == N) begin
                nt.e   = cyc + 1;
                nt.tag = cur_tag;
                nt.a   = cur_a;
                nt.b   = cur_b;
                tq.push_back(nt);
                pushed++;
                beats_loaded = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, W'($urandom), W'($urandom), 1'b1);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [6:0]   pat;
        int           e0;

        // Reset held for three cycles
        repeat (3) step(1'b0, '0, '0, 1'b0);
        idle(2);

        // Back-to-back tile of ones and twos
        cur_tag = 2;
        repeat (N) step(1'b1, {N{8'h01}}, {N{8'h02}}, 1'b1);
        idle(LAT + 2);

        // Skew pattern
        cur_tag = 3;
        for (int k = 0; k < N; k++) begin
            for (int l = 0; l < N; l++) begin
                a[8*l +: 8] = 8'(10*l + k);
                b[8*l +: 8] = 8'(100 + 10*k + l);
            end
            step(1'b1, a, b, 1'b1);
        end
        idle(LAT + 2);

        // Backpressure pattern 1,0,0,1,1,0,1
        cur_tag = 4;
        pat = 7'b1001101;
        for (int s = 6; s >= 0; s--) step(pat[s], W'($urandom), W'($urandom), 1'b1);
        idle(LAT + 2);

        // Valid held high with changing data while the tile is processed
        cur_tag = 5;
        repeat (N + LAT + 2) step(1'b1, W'($urandom), W'($urandom), 1'b1);
        idle(LAT + 2);

        // Reset during FEED t=2, then a fresh tile
        cur_tag = 6;
        repeat (N) step(1'b1, W'($urandom), W'($urandom), 1'b1);
        e0 = cyc + 1;
        while (cyc + 1 < e0 + 3) step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b0);
        cur_tag = 7;
        repeat (N) step(1'b1, W'($urandom), W'($urandom), 1'b1);
        idle(LAT + 2);

        // Random traffic with random gaps
        cur_tag = 0;
        repeat (800) step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 1'b1);
        idle(LAT + 3);

        chk("done_count", 64'(dones), 64'(pushed - aborted));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
